spi_slave_ctrl: RTL

- SPI slave front-end that sequences the single-port command RAM (RAM module) of the SPI project.
- Deserialises 10-bit MOSI frames into parallel command words (rx_data, rx_valid) for the RAM.
- On a read-data command, captures the RAM's returned byte (tx_data, tx_valid) and serialises it MSB-first on MISO.
- Sits between the SPI pins (SS_n, MOSI, MISO) and the RAM in the top-level wrapper.

---
 rtl/spi_slave_ctrl_pkg.sv | 23 ++
 rtl/spi_slave_ctrl_if.sv | 23 ++
 rtl/spi_miso_serializer.sv | 52 +++++
 rtl/spi_slave_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/spi_slave_ctrl_pkg.sv
// spi_pkg: shared definitions for the SPI slave controller slice.
//   state_t        - controller FSM states (3-bit encoding)
//   WR_ADDR..      - command opcodes carried in frame bits [9:8]
//   ADDR_SIZE_DEF  - default payload width; FRAME_W_DEF = payload + 2 opcode bits
package spi_pkg;

  localparam int ADDR_SIZE_DEF = 8;
  localparam int FRAME_W_DEF   = ADDR_SIZE_DEF + 2;

  localparam logic [1:0] WR_ADDR = 2'b00;
  localparam logic [1:0] WR_DATA = 2'b01;
  localparam logic [1:0] RD_ADDR = 2'b10;
  localparam logic [1:0] RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

endpackage

// File: rtl/spi_slave_ctrl_if.sv
// spi_slave_ctrl_if: parallel link between the SPI slave controller and the RAM.
//   rx_data  [ADDR_SIZE+1:0]  assembled frame {opcode, payload}   (ctrl -> RAM)
//   rx_valid                  one-cycle strobe, rx_data complete   (ctrl -> RAM)
//   tx_data  [ADDR_SIZE-1:0]  read byte                            (RAM -> ctrl)
//   tx_valid                  read byte valid                      (RAM -> ctrl)
// Handshake: both directions are strobe-qualified with no back-pressure.
// rx_data is meaningful only in the cycle rx_valid=1 (it holds afterwards
// but the RAM must act on the strobe). tx_data is sampled by the controller
// in the first tx_valid=1 cycle after a read-data frame; later tx_valid
// pulses are ignored until the next read-data frame.
interface spi_slave_ctrl_if #(
  parameter int ADDR_SIZE = 8
) ();

  logic [ADDR_SIZE+1:0] rx_data;
  logic                 rx_valid;
  logic [ADDR_SIZE-1:0] tx_data;
  logic                 tx_valid;

  modport master (output rx_data, rx_valid, input tx_data, tx_valid);
  modport slave  (input rx_data, rx_valid, output tx_data, tx_valid);

endinterface

// File: rtl/spi_miso_serializer.sv
// spi_miso_serializer: byte serialiser for the MISO readout, MSB first.
//   clk, rst_n  clock, async active-low reset
//   clear       synchronous flush: dout and state return to 0 next cycle
//   load        capture data; dout <= data[W-1] next cycle
//   data[W-1:0] byte to send
//   dout        serial output, 0 whenever no bit is being sent
//   busy        high while dout carries a payload bit
module spi_miso_serializer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] data,
  output logic         dout,
  output logic         busy
);

  localparam int RW = $clog2(W);

  // The MSB goes straight to dout on load, so only W-1 bits are held.
  logic [W-2:0] sh;
  logic [RW-1:0] rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh   <= '0;
      rem  <= '0;
      dout <= 1'b0;
      busy <= 1'b0;
    end else if (clear) begin
      sh   <= '0;
      rem  <= '0;
      dout <= 1'b0;
      busy <= 1'b0;
    end else if (load) begin
      sh   <= data[W-2:0];
      rem  <= RW'(W - 1);
      dout <= data[W-1];
      busy <= 1'b1;
    end else if (rem != '0) begin
      dout <= sh[W-2];
      sh   <= {sh[W-3:0], 1'b0};
      rem  <= rem - RW'(1);
    end else begin
      dout <= 1'b0;
      busy <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: SPI slave front-end sequencing the single-port command RAM.
//   clk, rst_n        system clock; async active-low reset
//   SS_n, MOSI        SPI select and serial input, sampled on rising clk
//   MISO              serial read data, MSB first, 0 outside a readout
//   ram               spi_slave_ctrl_if.master: rx_data/rx_valid out,
//                     tx_data/tx_valid in
//   state_dbg         current FSM state
//   addr_rcvd_dbg     a read address has been received, read data is next
//   readout_busy_dbg  MISO is carrying a read byte
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             SS_n,
  input  logic             MOSI,
  output logic             MISO,
  spi_slave_ctrl_if.master ram,
  output state_t           state_dbg,
  output logic             addr_rcvd_dbg,
  output logic             readout_busy_dbg
);

  localparam int FW = ADDR_SIZE + 2;
  localparam int CW = $clog2(FW + 1);

  state_t        state, next_state;
  logic [CW-1:0] bit_cnt;
  logic [FW-2:0] shift_reg;   // bits received before the last one
  logic [FW-1:0] rx_data_q;
  logic          rx_valid_q;
  logic          addr_rcvd;
  logic          tx_loaded;

  logic in_data, frame_last, frame_full, tx_load, ser_clear;

  assign in_data    = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
  assign frame_last = in_data && !SS_n && (bit_cnt == CW'(FW - 1));
  assign frame_full = (bit_cnt == CW'(FW));
  assign tx_load    = (state == READ_DATA) && !SS_n && frame_full &&
                      ram.tx_valid && !tx_loaded;
  // Any deselect or leaving READ_DATA flushes the readout next cycle.
  assign ser_clear  = SS_n || (state != READ_DATA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!SS_n) next_state = CHK_CMD;
      CHK_CMD: begin
        if (SS_n)           next_state = IDLE;
        else if (!MOSI)     next_state = WRITE;
        else if (addr_rcvd) next_state = READ_DATA;
        else                next_state = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: if (SS_n) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      shift_reg  <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      addr_rcvd  <= 1'b0;
      tx_loaded  <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt   <= '0;
          tx_loaded <= 1'b0;
        end
        CHK_CMD: begin
          tx_loaded <= 1'b0;
          if (SS_n) begin
            bit_cnt <= '0;
          end else begin
            shift_reg <= {{(FW - 2){1'b0}}, MOSI};
            bit_cnt   <= CW'(1);
          end
        end
        default: begin
          if (SS_n) begin
            bit_cnt   <= '0;
            tx_loaded <= 1'b0;
          end else begin
            if (bit_cnt < CW'(FW - 1)) shift_reg <= {shift_reg[FW-3:0], MOSI};
            if (!frame_full)           bit_cnt   <= bit_cnt + CW'(1);
            if (frame_last) begin
              rx_data_q  <= {shift_reg, MOSI};
              rx_valid_q <= 1'b1;
              if (state == READ_ADD)  addr_rcvd <= 1'b1;
              if (state == READ_DATA) addr_rcvd <= 1'b0;
            end
            if (tx_load) tx_loaded <= 1'b1;
          end
        end
      endcase
    end
  end

  spi_miso_serializer #(.W(ADDR_SIZE)) u_ser (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (ser_clear),
    .load  (tx_load),
    .data  (ram.tx_data),
    .dout  (MISO),
    .busy  (readout_busy_dbg)
  );

  assign ram.rx_data   = rx_data_q;
  assign ram.rx_valid  = rx_valid_q;
  assign state_dbg     = state;
  assign addr_rcvd_dbg = addr_rcvd;

endmodule
